// File: rtl/qed_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : qed_regfile_if
// Brief    : write/read/JTAG/QED bundle for qed_regfile (master = core side).
// Revision : 1.0
// ============================================================================
interface qed_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic                  we_i;
  logic [AW-1:0]         waddr_i;
  logic [XLEN-1:0]       wdata_i;
  logic                  commit_i;
  logic                  jtag_we_i;
  logic [AW-1:0]         jtag_addr_i;
  logic [XLEN-1:0]       jtag_data_i;
  logic [XLEN-1:0]       jtag_data_o;
  logic [NREAD*AW-1:0]   raddr_i;
  logic [NREAD*XLEN-1:0] rdata_o;
  logic                  qed_ready_o;
  logic                  qed_busy_o;
  logic                  qed_pass_o;
  logic                  qed_err_o;
  logic [AW-1:0]         qed_err_idx_o;

  modport master (
    output we_i, waddr_i, wdata_i, commit_i,
    output jtag_we_i, jtag_addr_i, jtag_data_i, raddr_i,
    input  jtag_data_o, rdata_o,
    input  qed_ready_o, qed_busy_o, qed_pass_o, qed_err_o, qed_err_idx_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, commit_i,
    input  jtag_we_i, jtag_addr_i, jtag_data_i, raddr_i,
    output jtag_data_o, rdata_o,
    output qed_ready_o, qed_busy_o, qed_pass_o, qed_err_o, qed_err_idx_o
  );
endinterface
`default_nettype wire

// File: rtl/qed_regfile.sv
`default_nettype none
// ============================================================================
// Module   : qed_regfile
// Brief    : parametrised register file with forwarding; QED_CHECK_EN adds
//            commit counters and an original/duplicate pair scanner.
// Revision : 1.0
// ============================================================================
module qed_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  qed_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]       r_regs [NREGS];
  logic [NREAD*XLEN-1:0] w_rdata;

  // Core write has priority; a conflicting JTAG write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.we_i && (bus.waddr_i != '0)) begin
      r_regs[bus.waddr_i] <= bus.wdata_i;
    end else if (bus.jtag_we_i && (bus.jtag_addr_i != '0)) begin
      r_regs[bus.jtag_addr_i] <= bus.jtag_data_i;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = bus.raddr_i[k*AW +: AW];
    assign w_rdata[k*XLEN +: XLEN] =
        (w_addr == '0)                         ? '0          :
        (bus.we_i && (w_addr == bus.waddr_i))  ? bus.wdata_i :
                                                 r_regs[w_addr];
  end

  assign bus.rdata_o     = w_rdata;
  assign bus.jtag_data_o = (bus.jtag_addr_i == '0) ? '0 : r_regs[bus.jtag_addr_i];

`ifdef QED_CHECK_EN
  localparam int                HALF      = NREGS / 2;
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;
  localparam logic [AW-1:0]     C_HALF    = AW'(HALF);
  localparam logic [AW-1:0]     C_LAST    = AW'(HALF - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_orig_cnt;
  logic [CNT_W-1:0] r_dup_cnt;
  logic             r_ready;
  logic             r_scanned;
  logic             r_pass;
  logic             r_err;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    r_err_idx;
  logic             w_orig_inc;
  logic             w_dup_inc;
  logic [AW-1:0]    w_dup_idx;
  logic             w_pair_eq;

  assign w_orig_inc = bus.commit_i && bus.we_i && (bus.waddr_i != '0) && (bus.waddr_i < C_HALF);
  assign w_dup_inc  = bus.commit_i && bus.we_i && (bus.waddr_i >= C_HALF);
  // idx stays below HALF, so OR-ing in the top address bit is idx+HALF.
  assign w_dup_idx  = r_idx | C_HALF;
  assign w_pair_eq  = (r_regs[r_idx] == r_regs[w_dup_idx]);

  // ready drops on any commit so a stale "balanced" never launches a scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_orig_cnt <= '0;
      r_dup_cnt  <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (w_orig_inc && (r_orig_cnt != C_CNT_MAX)) r_orig_cnt <= r_orig_cnt + 1'b1;
      if (w_dup_inc  && (r_dup_cnt  != C_CNT_MAX)) r_dup_cnt  <= r_dup_cnt  + 1'b1;
      r_ready <= !(w_orig_inc || w_dup_inc) && (r_orig_cnt == r_dup_cnt) && (r_orig_cnt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_scanned <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_err_idx <= '0;
    end else begin
      r_pass <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_ready && !r_scanned && !bus.we_i && !r_err) begin
            r_state <= S_SCAN;
            r_idx   <= AW'(1);
          end
        end
        S_SCAN: begin
          if (bus.we_i || bus.jtag_we_i) begin
            r_state <= S_IDLE;
          end else if (!w_pair_eq) begin
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
            r_state   <= S_IDLE;
          end else if (r_idx == C_LAST) begin
            r_pass    <= 1'b1;
            r_scanned <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_orig_inc || w_dup_inc) r_scanned <= 1'b0;
    end
  end

  assign bus.qed_ready_o   = r_ready;
  assign bus.qed_busy_o    = (r_state == S_SCAN);
  assign bus.qed_pass_o    = r_pass;
  assign bus.qed_err_o     = r_err;
  assign bus.qed_err_idx_o = r_err_idx;

  a_pass_consistent: assert property (@(posedge clk) disable iff (!rst)
    !(!r_pass && r_err && r_ready && (r_state == S_IDLE) && r_scanned));

`ifdef FORMAL
  logic r_seen_bal;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_seen_bal <= 1'b0;
    else if (r_ready) r_seen_bal <= 1'b1;
  end

  always_comb begin
    if (rst && !r_seen_bal)
      for (int i = 1; i < HALF; i++) assume (r_regs[i] == r_regs[i+HALF]);
  end
`endif
`else
  localparam int C_UNUSED_CNT_W = CNT_W;
  logic w_unused_commit;
  assign w_unused_commit = bus.commit_i;

  assign bus.qed_ready_o   = 1'b0;
  assign bus.qed_busy_o    = 1'b0;
  assign bus.qed_pass_o    = 1'b0;
  assign bus.qed_err_o     = 1'b0;
  assign bus.qed_err_idx_o = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_qed_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_qed_regfile
// Brief    : directed self-checking bench for qed_regfile (both QED_CHECK_EN builds).
// Revision : 1.0
// ============================================================================
module tb_qed_regfile;
  logic clk = 1'b0;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n;
  logic got;
  logic saw_busy;
  logic [63:0] acc;

  always #5 clk = ~clk;

  qed_regfile_if #(.XLEN(32), .NREGS(32), .NREAD(2)) b0 ();
  qed_regfile_if #(.XLEN(64), .NREGS(32), .NREAD(4)) b1 ();

  qed_regfile #(.XLEN(32), .NREGS(32), .NREAD(2), .CNT_W(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  qed_regfile #(.XLEN(64), .NREGS(32), .NREAD(4), .CNT_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.we_i = 1'b0; b0.waddr_i = '0; b0.wdata_i = '0; b0.commit_i = 1'b0;
    b0.jtag_we_i = 1'b0; b0.jtag_data_i = '0;
  endtask

  task automatic idle1();
    b1.we_i = 1'b0; b1.waddr_i = '0; b1.wdata_i = '0; b1.commit_i = 1'b0;
    b1.jtag_we_i = 1'b0; b1.jtag_addr_i = '0; b1.jtag_data_i = '0;
  endtask

  task automatic commit0(input logic [4:0] a, input logic [31:0] d);
    b0.we_i = 1'b1; b0.commit_i = 1'b1; b0.waddr_i = a; b0.wdata_i = d;
    step();
    idle0();
  endtask

  task automatic commit1(input logic [4:0] a, input logic [63:0] d);
    b1.we_i = 1'b1; b1.commit_i = 1'b1; b1.waddr_i = a; b1.wdata_i = d;
    step();
    idle1();
  endtask

  function automatic logic [31:0] rd0(input int k);
    return b0.rdata_o[k*32 +: 32];
  endfunction

  function automatic logic [63:0] rd1(input int k);
    return b1.rdata_o[k*64 +: 64];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle0(); idle1();
    b0.raddr_i = {5'd5, 5'd0};
    b0.jtag_addr_i = 5'd5;
    b1.raddr_i = '0;
    #2;
    chk("rst_rd_x0", rd0(0), 0);
    chk("rst_rd_x5", rd0(1), 0);
    chk("rst_jtag_x5", b0.jtag_data_o, 0);
    chk("rst_qed_outs", {b0.qed_ready_o, b0.qed_busy_o, b0.qed_pass_o, b0.qed_err_o, b0.qed_err_idx_o}, 0);
    repeat (2) step();
    rst = 1'b1;

    // forwarding and storage of x5
    b0.we_i = 1'b1; b0.waddr_i = 5'd5; b0.wdata_i = 32'hDEADBEEF;
    b0.raddr_i = {5'd5, 5'd5};
    #1;
    chk("fwd_x5", rd0(1), 32'hDEADBEEF);
    chk("jtag_no_fwd", b0.jtag_data_o, 0);
    step();
    idle0();
    #1;
    chk("stored_x5", rd0(0), 32'hDEADBEEF);
    chk("jtag_rd_x5", b0.jtag_data_o, 32'hDEADBEEF);

    // core vs JTAG conflict
    b0.we_i = 1'b1; b0.waddr_i = 5'd3; b0.wdata_i = 32'h11;
    b0.jtag_we_i = 1'b1; b0.jtag_addr_i = 5'd3; b0.jtag_data_i = 32'h22;
    step();
    idle0();
    b0.raddr_i = {5'd0, 5'd3};
    step();
    chk("conflict_x3", rd0(0), 32'h11);
    chk("conflict_jtag_rd", b0.jtag_data_o, 32'h11);

    // JTAG-only write
    b0.jtag_we_i = 1'b1; b0.jtag_addr_i = 5'd4; b0.jtag_data_i = 32'h44;
    step();
    idle0();
    b0.raddr_i = {5'd4, 5'd0};
    #1;
    chk("jtag_wr_x4", rd0(1), 32'h44);

    // x0 is hardwired, including forwarding
    b0.we_i = 1'b1; b0.waddr_i = 5'd0; b0.wdata_i = 32'hFF;
    b0.raddr_i = {5'd0, 5'd0}; b0.jtag_addr_i = 5'd0;
    #1;
    chk("x0_fwd", rd0(0), 0);
    step();
    idle0();
    chk("x0_rd", rd0(1), 0);
    chk("x0_jtag", b0.jtag_data_o, 0);

    // HALF index is an ordinary register
    b0.we_i = 1'b1; b0.waddr_i = 5'd16; b0.wdata_i = 32'h1616;
    step();
    idle0();
    b0.raddr_i = {5'd16, 5'd0};
    #1;
    chk("x16_rd", rd0(1), 32'h1616);

`ifdef QED_CHECK_EN
    rst = 1'b0; step(); rst = 1'b1;
    commit0(5'd1, 32'd7);
    commit0(5'd17, 32'd7);
    chk("ready_lag", b0.qed_ready_o, 0);
    step();
    chk("ready_bal", b0.qed_ready_o, 1);
    step();
    chk("busy_start", b0.qed_busy_o, 1);
    n = 0;
    while (b0.qed_busy_o && n < 40) begin n++; step(); end
    chk("scan_len", n, 15);
    chk("pass_pulse", b0.qed_pass_o, 1);
    chk("pass_no_err", b0.qed_err_o, 0);
    step();
    chk("pass_one_cycle", b0.qed_pass_o, 0);
    repeat (3) step();
    chk("scanned_idle", b0.qed_busy_o, 0);

    // write mid-scan aborts, then the scan retries
    commit0(5'd3, 32'd5);
    commit0(5'd19, 32'd5);
    repeat (5) step();
    chk("busy_before_abort", b0.qed_busy_o, 1);
    b0.we_i = 1'b1; b0.waddr_i = 5'd7; b0.wdata_i = 32'd0;
    step();
    idle0();
    chk("abort_busy", b0.qed_busy_o, 0);
    chk("abort_no_pass", b0.qed_pass_o, 0);
    chk("abort_no_err", b0.qed_err_o, 0);
    got = 1'b0; n = 0;
    while (!got && n < 40) begin step(); n++; if (b0.qed_pass_o) got = 1'b1; end
    chk("retry_pass", got, 1);
    chk("retry_no_err", b0.qed_err_o, 0);

    // mismatching pair 2
    commit0(5'd2, 32'd4);
    commit0(5'd18, 32'd9);
    n = 0;
    while (!b0.qed_err_o && n < 40) begin step(); n++; end
    chk("err_latency", n, 4);
    chk("err_flag", b0.qed_err_o, 1);
    chk("err_idx", b0.qed_err_idx_o, 2);
    chk("err_no_pass", b0.qed_pass_o, 0);
    commit0(5'd4, 32'd1);
    commit0(5'd20, 32'd1);
    saw_busy = 1'b0;
    repeat (20) begin step(); if (b0.qed_busy_o) saw_busy = 1'b1; end
    chk("err_sticky", b0.qed_err_o, 1);
    chk("err_idx_sticky", b0.qed_err_idx_o, 2);
    chk("err_blocks_scan", saw_busy, 0);

    // async reset clears error, and aborts a running scan immediately
    #2 rst = 1'b0;
    #1;
    chk("rst_clears_err", {b0.qed_err_o, b0.qed_err_idx_o}, 0);
    step(); rst = 1'b1;
    commit0(5'd1, 32'd1);
    commit0(5'd17, 32'd1);
    repeat (3) step();
    chk("busy_pre_rst", b0.qed_busy_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_scan_busy", b0.qed_busy_o, 0);
    chk("rst_mid_scan_ready", b0.qed_ready_o, 0);
    step(); rst = 1'b1;

    // saturation: 19 orig commits hold at 15, then 15 dup commits balance
    for (int i = 0; i < 19; i++) commit1(5'd1, 64'hA5);
    for (int i = 0; i < 14; i++) commit1(5'd17, 64'hA5);
    step();
    chk("sat_not_ready", b1.qed_ready_o, 0);
    commit1(5'd17, 64'hA5);
    step();
    chk("sat_ready", b1.qed_ready_o, 1);
    got = 1'b0; n = 0;
    while (!got && n < 40) begin step(); n++; if (b1.qed_pass_o) got = 1'b1; end
    chk("sat_pass", got, 1);
`else
    commit0(5'd1, 32'd7);
    commit0(5'd17, 32'd7);
    acc = '0;
    repeat (20) begin
      step();
      acc = acc | 64'({b0.qed_ready_o, b0.qed_busy_o, b0.qed_pass_o, b0.qed_err_o, b0.qed_err_idx_o});
    end
    chk("noqed_outputs", acc, 0);
    b0.raddr_i = {5'd17, 5'd1};
    #1;
    chk("noqed_commit_wr", {rd0(1), rd0(0)}, {32'd7, 32'd7});
`endif

    // four independent 64-bit read ports, port 3 forwarded
    b1.we_i = 1'b1; b1.waddr_i = 5'd2; b1.wdata_i = 64'h0123_4567_89AB_CDEF; step();
    b1.waddr_i = 5'd3; b1.wdata_i = 64'hFEDC_BA98_7654_3210; step();
    b1.waddr_i = 5'd4; b1.wdata_i = 64'h5555_AAAA_0000_FFFF; step();
    b1.waddr_i = 5'd10; b1.wdata_i = 64'hCAFE_F00D_1234_0000;
    b1.raddr_i = {5'd10, 5'd4, 5'd3, 5'd2};
    #1;
    chk("p4_port0", rd1(0), 64'h0123_4567_89AB_CDEF);
    chk("p4_port1", rd1(1), 64'hFEDC_BA98_7654_3210);
    chk("p4_port2", rd1(2), 64'h5555_AAAA_0000_FFFF);
    chk("p4_port3_fwd", rd1(3), 64'hCAFE_F00D_1234_0000);
    step();
    idle1();
    b1.raddr_i = {5'd2, 5'd10, 5'd0, 5'd4};
    #1;
    chk("p4_port0_b", rd1(0), 64'h5555_AAAA_0000_FFFF);
    chk("p4_port1_x0", rd1(1), 0);
    chk("p4_port2_b", rd1(2), 64'hCAFE_F00D_1234_0000);
    chk("p4_port3_b", rd1(3), 64'h0123_4567_89AB_CDEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
